traffic_phase_ctrl: RTL and testbench

- Parametrised multi-approach traffic-light controller. Successor to the team's fixed two-way controller.
- Sequences NUM_PH conflicting phases round-robin: green, then yellow, then all-red clearance. Also provides a night flashing-yellow mode and a countdown output for display drivers.
- Sits between the timing-configuration registers and the lamp driver outputs.

---
 rtl/traffic_phase_ctrl_pkg.sv | 24 ++
 rtl/traffic_phase_ctrl_if.sv | 27 ++
 rtl/traffic_phase_ctrl_down_timer.sv | 30 +++
 rtl/traffic_phase_ctrl.sv | 169 ++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/traffic_phase_ctrl_pkg.sv
// tpc_pkg: shared types and helpers for the traffic phase controller.
//   state_t   - controller state encoding
//   LAMP_*    - per-phase lamp code packed as {red, yellow, green}
//   clamp1()  - maps a zero duration to one cycle
package tpc_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_ALLRED = 3'd3,
    ST_FLASH  = 3'd4
  } state_t;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;

  function automatic logic [31:0] clamp1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: timing configuration in, lamp/countdown status out.
//   master - configuration side (drives durations and mode_flash)
//   slave  - controller side (drives lamps, cur_phase, remaining)
interface traffic_phase_ctrl_if #(
  parameter int NUM_PH = 2,
  parameter int CNT_W  = 8
) ();
  logic [CNT_W-1:0]  t_green;
  logic [CNT_W-1:0]  t_yellow;
  logic [CNT_W-1:0]  t_allred;
  logic              mode_flash;
  logic [NUM_PH-1:0] red;
  logic [NUM_PH-1:0] yellow;
  logic [NUM_PH-1:0] green;
  logic [1:0]        cur_phase;
  logic [CNT_W-1:0]  remaining;

  modport master (
    output t_green, t_yellow, t_allred, mode_flash,
    input  red, yellow, green, cur_phase, remaining
  );

  modport slave (
    input  t_green, t_yellow, t_allred, mode_flash,
    output red, yellow, green, cur_phase, remaining
  );
endinterface

// File: rtl/traffic_phase_ctrl_down_timer.sv
// tpc_down_timer: loadable down-counter that stops at zero.
//   clk, rst_n - clock, async active-low reset (count clears to 0)
//   load/load_val - load has priority over decrement
//   dec        - decrement by one while count is non-zero
//   count      - current value; expire - count == 1 (last cycle of a state)
module tpc_down_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin green/yellow/all-red sequencer for NUM_PH
// conflicting approaches, with night flashing-yellow mode.
//   clk, rst_n - clock, async active-low reset (all-red INIT)
//   bus        - slave side of traffic_phase_ctrl_if: durations and
//                mode_flash in; red/yellow/green, cur_phase, remaining out
//
// state  | meaning
// INIT   | one cycle after reset, all red
// ALLRED | clearance between phases, all red
// GREEN  | cur_phase green, others red
// YELLOW | cur_phase yellow, others red
// FLASH  | all yellows blink, no red/green
module traffic_phase_ctrl
  import tpc_pkg::*;
#(
  parameter int NUM_PH     = 2,
  parameter int CNT_W      = 8,
  parameter int FLASH_HALF = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  traffic_phase_ctrl_if.slave bus
);

  localparam int FH_W = $clog2(FLASH_HALF + 1);

  state_t            state, nxt_state;
  logic [1:0]        cur_q, nxt_cur;
  logic [1:0]        pend_q, nxt_pend;
  logic              tog_q, nxt_tog;
  logic [FH_W-1:0]   fcnt_q, nxt_fcnt;
  logic [NUM_PH-1:0] red_q, yel_q, grn_q;
  logic [NUM_PH-1:0] red_d, yel_d, grn_d;
  logic [2:0]        lamp;

  logic              tmr_ld, tmr_dec, tmr_exp;
  logic [CNT_W-1:0]  tmr_val, tmr_cnt;
  logic [CNT_W-1:0]  l_green, l_yellow, l_allred;

  function automatic logic [1:0] next_ph(input logic [1:0] p);
    return (p == 2'(NUM_PH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign l_green  = CNT_W'(clamp1(32'(bus.t_green)));
  assign l_yellow = CNT_W'(clamp1(32'(bus.t_yellow)));
  assign l_allred = CNT_W'(clamp1(32'(bus.t_allred)));

  assign tmr_dec = (state == ST_GREEN) || (state == ST_YELLOW) || (state == ST_ALLRED);

  tpc_down_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_ld),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .count    (tmr_cnt),
    .expire   (tmr_exp)
  );

  always_comb begin
    nxt_state = state;
    nxt_cur   = cur_q;
    nxt_pend  = pend_q;
    nxt_tog   = tog_q;
    nxt_fcnt  = fcnt_q;
    tmr_ld    = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_INIT: begin
        nxt_state = ST_ALLRED;
        nxt_pend  = 2'd0;
        tmr_ld    = 1'b1;
        tmr_val   = l_allred;
      end
      ST_ALLRED: begin
        if (tmr_exp) begin
          tmr_ld = 1'b1;
          if (bus.mode_flash) begin
            // timer parked at 0 so remaining reads 0 while flashing
            nxt_state = ST_FLASH;
            nxt_tog   = 1'b1;
            nxt_fcnt  = FH_W'(FLASH_HALF);
          end else begin
            nxt_state = ST_GREEN;
            nxt_cur   = pend_q;
            tmr_val   = l_green;
          end
        end
      end
      ST_GREEN: begin
        // flash request cuts green short but always passes through yellow
        if (tmr_exp || bus.mode_flash) begin
          nxt_state = ST_YELLOW;
          tmr_ld    = 1'b1;
          tmr_val   = l_yellow;
        end
      end
      ST_YELLOW: begin
        if (tmr_exp) begin
          nxt_state = ST_ALLRED;
          nxt_pend  = next_ph(cur_q);
          tmr_ld    = 1'b1;
          tmr_val   = l_allred;
        end
      end
      ST_FLASH: begin
        if (!bus.mode_flash) begin
          nxt_state = ST_ALLRED;
          nxt_pend  = 2'd0;
          nxt_tog   = 1'b0;
          tmr_ld    = 1'b1;
          tmr_val   = l_allred;
        end else if (fcnt_q == FH_W'(1)) begin
          nxt_tog  = ~tog_q;
          nxt_fcnt = FH_W'(FLASH_HALF);
        end else begin
          nxt_fcnt = fcnt_q - 1'b1;
        end
      end
      default: nxt_state = ST_INIT;
    endcase
  end

  // Lamps are decoded from next-state values and registered alongside state.
  always_comb begin
    red_d = '0;
    yel_d = '0;
    grn_d = '0;
    lamp  = LAMP_R;
    for (int i = 0; i < NUM_PH; i++) begin
      case (nxt_state)
        ST_GREEN:  lamp = (nxt_cur == 2'(i)) ? LAMP_G : LAMP_R;
        ST_YELLOW: lamp = (nxt_cur == 2'(i)) ? LAMP_Y : LAMP_R;
        ST_FLASH:  lamp = nxt_tog ? LAMP_Y : LAMP_OFF;
        default:   lamp = LAMP_R;
      endcase
      {red_d[i], yel_d[i], grn_d[i]} = lamp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      cur_q  <= 2'd0;
      pend_q <= 2'd0;
      tog_q  <= 1'b0;
      fcnt_q <= '0;
      red_q  <= '1;
      yel_q  <= '0;
      grn_q  <= '0;
    end else begin
      state  <= nxt_state;
      cur_q  <= nxt_cur;
      pend_q <= nxt_pend;
      tog_q  <= nxt_tog;
      fcnt_q <= nxt_fcnt;
      red_q  <= red_d;
      yel_q  <= yel_d;
      grn_q  <= grn_d;
    end
  end

  assign bus.red       = red_q;
  assign bus.yellow    = yel_q;
  assign bus.green     = grn_q;
  assign bus.cur_phase = cur_q;
  assign bus.remaining = tmr_cnt;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with NUM_PH=3, FLASH_HALF=4.
// Observed vector packs {cur_phase, remaining, red, yellow, green}.
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl_if #(.NUM_PH(3), .CNT_W(8)) bus ();

  traffic_phase_ctrl #(.NUM_PH(3), .CNT_W(8), .FLASH_HALF(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] obs();
    return {bus.cur_phase, bus.remaining, bus.red, bus.yellow, bus.green};
  endfunction

  function automatic logic [18:0] vg(input int p, input int rem);
    logic [2:0] m;
    m = 3'b001 << p;
    return {2'(p), 8'(rem), ~m, 3'b000, m};
  endfunction

  function automatic logic [18:0] vy(input int p, input int rem);
    logic [2:0] m;
    m = 3'b001 << p;
    return {2'(p), 8'(rem), ~m, m, 3'b000};
  endfunction

  function automatic logic [18:0] var_(input int cur, input int rem);
    return {2'(cur), 8'(rem), 3'b111, 3'b000, 3'b000};
  endfunction

  function automatic logic [18:0] vfl(input int cur, input logic t);
    return {2'(cur), 8'd0, 3'b000, (t ? 3'b111 : 3'b000), 3'b000};
  endfunction

  task automatic step(input string tag, input logic [18:0] e);
    @(posedge clk);
    @(negedge clk);
    check(tag, 32'(obs()), 32'(e));
  endtask

  // green L cycles, yellow L cycles, all-red L cycles for phase p
  task automatic run_round(input int p, input int lg, input int ly, input int la);
    for (int r = lg; r >= 1; r--) step("green", vg(p, r));
    for (int r = ly; r >= 1; r--) step("yellow", vy(p, r));
    for (int r = la; r >= 1; r--) step("allred", var_(p, r));
  endtask

  task automatic do_reset(input int tg, input int ty, input int ta);
    @(negedge clk);
    rst_n          = 1'b0;
    bus.mode_flash = 1'b0;
    bus.t_green    = 8'(tg);
    bus.t_yellow   = 8'(ty);
    bus.t_allred   = 8'(ta);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] pr_g, pr_y, r, y, g;
    logic [3:0] viol;
    bus.mode_flash = 1'b0;
    bus.t_green    = 8'd5;
    bus.t_yellow   = 8'd2;
    bus.t_allred   = 8'd1;

    // reset state while held
    @(negedge clk);
    @(negedge clk);
    check("reset", 32'(obs()), 32'(var_(0, 0)));

    // normal cycle: INIT 1, ALLRED 1, then 24-cycle period wrapping to phase 0
    do_reset(5, 2, 1);
    check("init", 32'(obs()), 32'(var_(0, 0)));
    step("first_allred", var_(0, 1));
    run_round(0, 5, 2, 1);
    run_round(1, 5, 2, 1);
    run_round(2, 5, 2, 1);
    step("wrap_g0", vg(0, 5));

    // all durations zero: 3 cycles per phase
    do_reset(0, 0, 0);
    step("z_allred", var_(0, 1));
    for (int k = 0; k < 6; k++) run_round(k % 3, 1, 1, 1);
    step("z_wrap", vg(0, 1));

    // only yellow zero
    do_reset(5, 0, 1);
    step("zy_allred", var_(0, 1));
    run_round(0, 5, 1, 1);
    step("zy_g1", vg(1, 5));

    // mid-state config change
    do_reset(5, 2, 1);
    step("cfg_allred", var_(0, 1));
    run_round(0, 5, 2, 1);
    step("cfg_g1", vg(1, 5));
    step("cfg_g1", vg(1, 4));
    step("cfg_g1", vg(1, 3));
    bus.t_green = 8'd9;
    step("cfg_g1_keep", vg(1, 2));
    step("cfg_g1_keep", vg(1, 1));
    step("cfg_y1", vy(1, 2));
    step("cfg_y1", vy(1, 1));
    step("cfg_ar", var_(1, 1));
    run_round(2, 9, 2, 1);
    step("cfg_g0", vg(0, 9));
    bus.t_green = 8'd5;

    // flash entry at green cycle 2 of phase 1, then exit
    do_reset(5, 2, 1);
    step("fl_allred", var_(0, 1));
    run_round(0, 5, 2, 1);
    step("fl_g1", vg(1, 5));
    step("fl_g1", vg(1, 4));
    bus.mode_flash = 1'b1;
    step("fl_y1", vy(1, 2));
    step("fl_y1", vy(1, 1));
    step("fl_ar", var_(1, 1));
    for (int k = 0; k < 12; k++) step("flash", vfl(1, ((k / 4) % 2) == 0));
    bus.mode_flash = 1'b0;
    step("fl_exit_ar", var_(1, 1));
    step("fl_exit_g0", vg(0, 5));

    // async reset between edges mid-yellow
    do_reset(5, 2, 1);
    step("ar_allred", var_(0, 1));
    for (int r2 = 5; r2 >= 1; r2--) step("ar_green", vg(0, r2));
    step("ar_y0", vy(0, 2));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'(obs()), 32'(var_(0, 0)));
    @(negedge clk);
    rst_n = 1'b1;

    // random mode_flash run with safety invariants
    pr_g = 3'b000;
    pr_y = 3'b000;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.mode_flash = ~bus.mode_flash;
      @(posedge clk);
      @(negedge clk);
      r = bus.red;
      y = bus.yellow;
      g = bus.green;
      viol = 4'b0000;
      if (r != 3'b000) begin
        if ($countones(y | g) > 1) viol[0] = 1'b1;
        if (((r & y) | (r & g) | (y & g)) != 3'b000 || (r | y | g) != 3'b111) viol[1] = 1'b1;
      end
      if (pr_g != 3'b000 && g != 3'b000 && g != pr_g) viol[2] = 1'b1;
      if (pr_y != 3'b000 && r != 3'b000 && g != 3'b000) viol[3] = 1'b1;
      check("invariant", 32'(viol), 32'd0);
      pr_g = g;
      pr_y = (r != 3'b000) ? y : 3'b000;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
